// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, issues one instruction-memory request
// at a time and buffers returned words in a 2-entry queue toward decode. Redirects flush the
// queue and discard any wrong-path fetch still in flight.
// Optional macro FETCH_STALL_CNT_EN enables the saturating stall_cycles counter; without it
// stall_cycles is tied to zero.
module fetch_ctrl #(
  parameter int unsigned ADDR_W  = 48,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_INC  = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  pc_cur,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               id_ready,
  output logic [31:0]        stall_cycles
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StKill,
    StWait
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [1:0]          count_q, count_d;
  logic [INSTR_W-1:0]  head_instr_q, head_instr_d;
  logic [INSTR_W-1:0]  tail_instr_q, tail_instr_d;
  logic [ADDR_W-1:0]   head_pc_q, head_pc_d;
  logic [ADDR_W-1:0]   tail_pc_q, tail_pc_d;

  logic push;
  logic pop;
  logic issue;

  // Memory-side and PC-side combinational outputs.
  always_comb begin
    imem_req  = (state_q == StReq) || (state_q == StKill);
    imem_addr = imem_addr_q;
    pc_en     = redirect_valid || ((state_q == StReq) && imem_ack);
    pc_next   = redirect_valid ? redirect_target : (imem_addr_q + ADDR_W'(PC_INC));
    id_valid  = (count_q != 2'd0);
    id_instr  = head_instr_q;
    id_pc     = head_pc_q;
    // A redirect cancels both the same-cycle push and pop.
    push      = (state_q == StReq) && imem_ack && !redirect_valid;
    pop       = id_valid && id_ready && !redirect_valid;
  end

  // Queue next-state: head always lives in head_*; the tail shifts forward on pop.
  always_comb begin
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_instr_d = imem_rdata;
            head_pc_d    = imem_addr_q;
          end else begin
            tail_instr_d = imem_rdata;
            tail_pc_d    = imem_addr_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_instr_d = tail_instr_q;
          head_pc_d    = tail_pc_q;
          count_d      = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_instr_d = imem_rdata;
            head_pc_d    = imem_addr_q;
          end else begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            tail_instr_d = imem_rdata;
            tail_pc_d    = imem_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM next-state and request issue; a new request only goes out if the queue will have room
  // for its ack, so an ack never meets a full queue.
  always_comb begin
    state_d     = state_q;
    imem_addr_d = imem_addr_q;
    issue       = 1'b0;
    if (redirect_valid) begin
      unique case (state_q)
        StReq: begin
          if (imem_ack) begin
            issue = 1'b1;
          end else begin
            // The in-flight fetch is now wrong-path; keep the address stable until it acks.
            state_d = StKill;
          end
        end
        StKill:  issue = imem_ack;
        StIdle:  issue = 1'b1;
        StWait:  issue = 1'b1;
        default: ;
      endcase
    end else begin
      unique case (state_q)
        StIdle: issue = 1'b1;
        StReq: begin
          if (imem_ack) begin
            if (count_d < 2'd2) begin
              issue = 1'b1;
            end else begin
              state_d = StWait;
            end
          end
        end
        StWait:  issue = (count_d < 2'd2);
        StKill:  issue = imem_ack;
        default: ;
      endcase
    end
    if (issue) begin
      state_d     = StReq;
      imem_addr_d = pc_en ? pc_next : pc_cur;
    end
  end

  // State, request address and queue registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      imem_addr_q  <= '0;
      count_q      <= 2'd0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      imem_addr_q  <= imem_addr_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        stalled;

  // Count cycles where no useful instruction returns: waiting on queue space, draining a
  // wrong-path fetch, or waiting on memory. Saturates instead of wrapping.
  always_comb begin
    stalled = (state_q == StWait) || (state_q == StKill) || ((state_q == StReq) && !imem_ack);
    stall_d = stall_q;
    if (stalled && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized self-checking bench for fetch_ctrl. A transaction-level model (outstanding request
// flag, wrong-path flag, decode queue as an SV queue, PC register) predicts every output each
// cycle; a small memory model answers requests with an address-derived word after a random
// latency.
module tb_fetch_ctrl;
  localparam int unsigned ADDR_W  = 48;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_INC  = 1;
  localparam logic [63:0] AMASK   = 64'h0000_FFFF_FFFF_FFFF;

  logic               Clk = 1'b0;
  logic               Reset = 1'b0;
  logic [ADDR_W-1:0]  pc_cur;
  logic [ADDR_W-1:0]  pc_next;
  logic               pc_en;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic               id_ready;
  logic [31:0]        stall_cycles;

  fetch_ctrl #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .PC_INC (PC_INC)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .pc_cur         (pc_cur),
    .pc_next        (pc_next),
    .pc_en          (pc_en),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready),
    .stall_cycles   (stall_cycles)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30) begin
        $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [63:0] a);
    return a[15:0] ^ a[31:16] ^ a[47:32] ^ 16'h5a3c;
  endfunction

  // Reference model state.
  logic [63:0] q_instr[$];
  logic [63:0] q_pc[$];
  bit          m_out;      // a request is outstanding
  bit          m_kill;     // the outstanding request is wrong-path
  bit          m_started;  // at least one edge since reset
  logic [63:0] m_addr;     // address of the most recently issued request
  logic [63:0] m_pc;       // PC register contents
  logic [31:0] m_stall;
  int          lat_left;   // cycles until the memory acks the current request

  // One clock cycle: drive inputs at posedge+1, check at posedge+4, advance the model.
  task automatic run_cycle(input int redir_pct, input int ready_pct, input int lat_min,
                           input int lat_max, input logic [63:0] tgt_fix);
    logic [63:0] tgt, exp_next;
    bit          redir, rdy, ack, pen, push, pop, stalled;
    redir = ($urandom_range(99) < redir_pct);
    tgt   = {$urandom(), $urandom()} & AMASK;
    if ($urandom_range(7) == 0) tgt = AMASK;
    if (tgt_fix != 64'd0) tgt = tgt_fix;
    rdy = ($urandom_range(99) < ready_pct);
    ack = m_out && (lat_left == 0);

    redirect_valid  = redir;
    redirect_target = tgt[ADDR_W-1:0];
    id_ready        = rdy;
    imem_ack        = ack;
    imem_rdata      = mem_word(64'(imem_addr));
    pc_cur          = m_pc[ADDR_W-1:0];
    #3;

    pen      = redir || (m_out && !m_kill && ack);
    exp_next = redir ? tgt : ((m_addr + 64'(PC_INC)) & AMASK);
    check_eq("imem_req", 64'(imem_req), 64'(m_out));
    check_eq("imem_addr", 64'(imem_addr), m_addr);
    check_eq("pc_en", 64'(pc_en), 64'(pen));
    check_eq("pc_next", 64'(pc_next), exp_next);
    check_eq("id_valid", 64'(id_valid), 64'(q_pc.size() != 0));
    if (q_pc.size() != 0) begin
      check_eq("id_instr", 64'(id_instr), q_instr[0]);
      check_eq("id_pc", 64'(id_pc), q_pc[0]);
    end
`ifdef FETCH_STALL_CNT_EN
    check_eq("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`else
    check_eq("stall_cycles", 64'(stall_cycles), 64'(m_stall & 32'd0));
`endif

    // Stall: waiting for queue space, draining wrong-path, or memory not yet answering.
    stalled = m_started && (!m_out || m_kill || !ack);
    if (stalled && (m_stall != 32'hFFFF_FFFF)) m_stall++;

    pop  = (q_pc.size() != 0) && rdy;
    push = m_out && !m_kill && ack;
    if (redir) begin
      q_instr.delete();
      q_pc.delete();
    end else begin
      if (pop) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (push) begin
        q_instr.push_back(64'(mem_word(m_addr)));
        q_pc.push_back(m_addr);
      end
    end

    if (m_out && !ack) begin
      if (redir) m_kill = 1'b1;
      lat_left--;
    end else if (redir || !m_started || (q_pc.size() <= 1)) begin
      m_out    = 1'b1;
      m_kill   = 1'b0;
      m_addr   = pen ? exp_next : m_pc;
      lat_left = int'($urandom_range(lat_max, lat_min));
    end else begin
      m_out = 1'b0;
    end
    m_started = 1'b1;
    if (pen) m_pc = exp_next;

    @(posedge Clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset(input logic [63:0] start_pc);
    Reset          = 1'b1;
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    id_ready       = 1'b0;
    #1;
    check_eq("rst_imem_req", 64'(imem_req), 64'd0);
    check_eq("rst_imem_addr", 64'(imem_addr), 64'd0);
    check_eq("rst_id_valid", 64'(id_valid), 64'd0);
    check_eq("rst_id_instr", 64'(id_instr), 64'd0);
    check_eq("rst_id_pc", 64'(id_pc), 64'd0);
    check_eq("rst_stall", 64'(stall_cycles), 64'd0);
    q_instr.delete();
    q_pc.delete();
    m_out     = 1'b0;
    m_kill    = 1'b0;
    m_started = 1'b0;
    m_addr    = 64'd0;
    m_stall   = 32'd0;
    lat_left  = 0;
    m_pc      = start_pc & AMASK;
    pc_cur    = m_pc[ADDR_W-1:0];
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_ack        = 1'b0;
    imem_rdata      = '0;
    id_ready        = 1'b0;
    pc_cur          = '0;
    #2;
    do_reset(64'd0);

    // Streaming fetch with single-cycle memory and an always-ready decoder.
    repeat (12) run_cycle(0, 100, 0, 0, 64'd0);
    // Decoder stalled: queue fills, controller parks, then drains in order.
    repeat (8) run_cycle(0, 0, 0, 0, 64'd0);
    repeat (8) run_cycle(0, 100, 0, 0, 64'd0);
    // Fixed 3-cycle memory latency.
    repeat (18) run_cycle(0, 100, 2, 2, 64'd0);
    // Redirect to 0x100 during a slow request, then let the wrong-path ack drain.
    repeat (2) run_cycle(0, 100, 2, 2, 64'd0);
    run_cycle(100, 100, 2, 2, 64'h100);
    repeat (10) run_cycle(0, 100, 2, 2, 64'd0);
    // Redirect to 0x40 coinciding with an ack and a ready decoder.
    repeat (4) run_cycle(0, 100, 0, 0, 64'd0);
    run_cycle(100, 100, 0, 0, 64'h40);
    repeat (6) run_cycle(0, 100, 0, 0, 64'd0);

    // Reset mid-request with the queue full, restarting from a random PC.
    for (int r = 0; r < 6; r++) begin
      repeat (6) run_cycle(0, 0, 0, 1, 64'd0);
      repeat ($urandom_range(2)) run_cycle(0, 0, 2, 3, 64'd0);
      do_reset({$urandom(), $urandom()});
      repeat (20) run_cycle(5, 70, 0, 2, 64'd0);
    end

    // Broad random traffic with varying redirect, readiness and latency mixes.
    repeat (1500) run_cycle(10, 60, 0, 3, 64'd0);
    repeat (1000) run_cycle(30, 30, 0, 1, 64'd0);
    repeat (1000) run_cycle(3, 90, 0, 0, 64'd0);
    repeat (500)  run_cycle(15, 20, 1, 4, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
